option_fifo_sequencer: RTL and testbench

- Circular buffer that feeds the line solver. It holds an interleaved stream of line-index markers, each followed by that line's candidate options.
- It presents one entry at a time to the solver.
- Line markers are automatically re-queued at the tail.
- Each option is re-queued or discarded according to the solver's keep/drop verdict.
- Upstream loader writes the initial stream in LOAD; the solver consumes it in RUN until flushed.

---
 rtl/option_fifo_sequencer.sv | 98 +++++++++
 tb/tb_option_fifo_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/option_fifo_sequencer.sv
// option_fifo_sequencer: circular buffer of line markers and options feeding the line solver.
// Markers recirculate on pop. Options are held until a keep/drop verdict arrives.
module option_fifo_sequencer #(
    parameter int SIZE  = 3,
    parameter int DW    = 3,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_valid_i,
    output logic                     load_ready_o,
    input  logic                     load_is_line_i,
    input  logic [DW-1:0]            load_data_i,
    input  logic                     load_last_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_is_line_o,
    output logic [DW-1:0]            out_data_o,
    input  logic                     wb_valid_i,
    input  logic                     wb_keep_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int AW = $clog2(DEPTH);

    if (DW < SIZE || DW < $clog2(2 * SIZE) || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("option_fifo_sequencer: illegal DW or DEPTH");
    end

    typedef enum logic {LOAD, RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   occ_q, occ_d;
    logic          busy_q, busy_d, err_q, err_d;
    logic [DW:0]   hold_q, hold_d;
    logic [DW:0]   mem_q [DEPTH];

    logic [DW:0] head_entry, wr_data;
    logic        load_acc, pop, pop_line, pop_opt, verdict, requeue, wr_en;

    assign head_entry    = mem_q[head_q];
    assign out_is_line_o = head_entry[DW];
    assign out_data_o    = head_entry[DW-1:0];
    // The top occupancy bit is set only when all DEPTH slots are filled.
    assign load_ready_o  = (state_q == LOAD) & ~occ_q[AW];
    assign out_valid_o   = (state_q == RUN) & (occ_q != '0) & ~busy_q;
    assign occupancy_o   = occ_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

    always_comb begin
        load_acc = load_valid_i & load_ready_o;
        pop      = out_valid_o & out_ready_i;
        pop_line = pop & out_is_line_o;
        pop_opt  = pop & ~out_is_line_o;
        verdict  = wb_valid_i & busy_q;
        requeue  = verdict & wb_keep_i;
        // Load, marker pop and verdict are mutually exclusive, so one write port suffices.
        wr_en    = ~flush_i & (load_acc | pop_line | requeue);
        wr_data  = load_acc ? {load_is_line_i, load_data_i} : pop_line ? head_entry : hold_q;
        state_d  = flush_i ? LOAD : (load_acc & load_last_i) ? RUN : state_q;
        head_d   = flush_i ? '0 : pop ? head_q + 1'b1 : head_q;
        tail_d   = flush_i ? '0 : wr_en ? tail_q + 1'b1 : tail_q;
        occ_d    = flush_i ? '0 : occ_q + (AW+1)'(load_acc | requeue) - (AW+1)'(pop_opt);
        busy_d   = ~flush_i & (pop_opt | (busy_q & ~verdict));
        hold_d   = pop_opt ? head_entry : hold_q;
        err_d    = err_q | (~flush_i & ((wb_valid_i & ~busy_q)
                 | (load_valid_i & (state_q != LOAD))
                 | (load_valid_i & load_last_i & ~load_ready_o & (state_q == LOAD))));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[tail_q] <= wr_data;
    end
endmodule

// File: tb/tb_option_fifo_sequencer.sv
// tb_option_fifo_sequencer: directed bench with a reference queue of stored entries.
module tb_option_fifo_sequencer;
    localparam int DW    = 3;
    localparam int DEPTH = 64;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          load_valid = 1'b0, load_is_line = 1'b0, load_last = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          out_ready = 1'b0, wb_valid = 1'b0, wb_keep = 1'b0, flush = 1'b0;
    logic          load_ready, out_valid, out_is_line, busy, err;
    logic [DW-1:0] out_data;
    logic [6:0]    occupancy;

    int          n_vec = 0, n_err = 0;
    logic [DW:0] mq[$];
    logic [DW:0] held;

    option_fifo_sequencer #(.SIZE(3), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .load_valid_i(load_valid), .load_ready_o(load_ready), .load_is_line_i(load_is_line),
        .load_data_i(load_data), .load_last_i(load_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_is_line_o(out_is_line),
        .out_data_o(out_data), .wb_valid_i(wb_valid), .wb_keep_i(wb_keep), .flush_i(flush),
        .occupancy_o(occupancy), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic il, input logic [DW-1:0] d, input logic last);
        check("load_ready", load_ready, mq.size() < DEPTH);
        load_valid = 1'b1; load_is_line = il; load_data = d; load_last = last;
        tick;
        load_valid = 1'b0; load_last = 1'b0;
        mq.push_back({il, d});
    endtask

    task automatic pop_entry;
        logic [DW:0] e;
        e = mq.pop_front();
        check("pop_valid", out_valid, 1);
        check("pop_entry", {out_is_line, out_data}, e);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        if (e[DW]) mq.push_back(e); else held = e;
        check("busy_after_pop", busy, !e[DW]);
        check("occ_after_pop", occupancy, mq.size());
    endtask

    task automatic verdict(input logic keep);
        wb_valid = 1'b1; wb_keep = keep;
        tick;
        wb_valid = 1'b0;
        if (keep) mq.push_back(held);
        check("busy_after_verdict", busy, 0);
        check("occ_after_verdict", occupancy, mq.size());
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        mq.delete();
    endtask

    initial begin
        @(negedge clk);
        check("rst_occ", occupancy, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_load_ready", load_ready, 1);
        rst_n = 1'b1;
        tick;

        load(1'b1, 3'd0, 1'b0);
        load(1'b0, 3'b101, 1'b0);
        load(1'b0, 3'b011, 1'b0);
        load(1'b1, 3'd3, 1'b0);
        check("load_out_valid", out_valid, 0);
        load(1'b0, 3'b110, 1'b1);
        check("run_occ", occupancy, 5);
        check("run_load_ready", load_ready, 0);
        check("run_head", {out_is_line, out_data}, 4'b1000);

        pop_entry;
        check("after_l0_head", {out_is_line, out_data}, 4'b0101);

        pop_entry;
        for (int i = 0; i < 3; i++) begin
            check("hold_busy", busy, 1);
            check("hold_out_valid", out_valid, 0);
            tick;
        end
        verdict(1'b0);
        check("drop_occ", occupancy, 4);
        check("drop_head", {out_is_line, out_data}, 4'b0011);

        pop_entry;
        verdict(1'b1);
        check("keep_occ", occupancy, 4);
        for (int i = 0; i < 4; i++) begin
            pop_entry;
            if (busy) verdict(1'b1);
        end
        check("rot_head", {out_is_line, out_data}, 4'b1011);

        pop_entry;
        pop_entry;
        check("busy_before_flush", busy, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        mq.delete();
        check("flush_busy", busy, 0);
        check("flush_occ", occupancy, 0);
        check("flush_load_ready", load_ready, 1);
        check("flush_err", err, 0);

        for (int i = 0; i < DEPTH; i++) load(i[0], DW'(i), 1'b0);
        check("full_occ", occupancy, DEPTH);
        check("full_load_ready", load_ready, 0);
        load_valid = 1'b1; load_data = 3'd7;
        tick;
        load_valid = 1'b0;
        check("held_off_occ", occupancy, DEPTH);
        check("held_off_err", err, 0);
        load_valid = 1'b1; load_last = 1'b1;
        tick;
        load_valid = 1'b0; load_last = 1'b0;
        check("last_full_err", err, 1);
        do_reset;
        check("err_cleared", err, 0);

        for (int i = 0; i < 60; i++) begin
            logic il;
            il = (i % 3 == 0);
            load(il, il ? DW'(i % 6) : DW'(i % 7 + 1), i == 59);
        end
        for (int j = 0; j < 90; j++) begin
            pop_entry;
            if (busy) begin
                for (int k = 0; k < j % 3; k++) begin
                    check("wrap_stall", out_valid, 0);
                    tick;
                end
                verdict(j[0]);
            end
        end
        check("wrap_occ", occupancy, mq.size());

        wb_valid = 1'b1;
        tick;
        wb_valid = 1'b0;
        check("stray_wb_err", err, 1);
        check("stray_wb_occ", occupancy, mq.size());

        #2 rst_n = 1'b0;
        #1;
        check("async_occ", occupancy, 0);
        check("async_err", err, 0);
        check("async_busy", busy, 0);
        check("async_out_valid", out_valid, 0);
        check("async_load_ready", load_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();

        load(1'b0, 3'b010, 1'b1);
        pop_entry;
        verdict(1'b0);
        tick;
        check("empty_out_valid", out_valid, 0);
        check("empty_occ", occupancy, 0);
        check("empty_still_run", load_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
